// File: rtl/cdb_pkg.sv
// Shared types and sizing for the CDB result arbiter.
// Optional feature macro used by the arbiter top: CDB_ARB_FLUSH_EN.
package cdb_pkg;

    localparam int unsigned NUM_FU         = 4;
    localparam int unsigned DEF_MAX_GRANTS = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 2;
    localparam int unsigned PREG_W         = 7;
    localparam int unsigned VAL_W          = 32;
    localparam int unsigned TAG_W          = 5;
    localparam int unsigned PC_W           = 32;
    localparam int unsigned RR_W           = $clog2(NUM_FU);
    localparam int unsigned RR_PW          = RR_W + 1;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [VAL_W-1:0]  val;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   pc;
        logic              taken;
    } cdb_entry_t;

    // Modulo-NUM_FU addition used by the round-robin scan.
    function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] base,
                                              input logic [RR_W:0]   inc);
        logic [RR_W:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= RR_PW'(NUM_FU)) begin
            sum = sum - RR_PW'(NUM_FU);
        end
        return sum[RR_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arb_fifo.sv
// Per-FU result queue: power-of-two depth, extra pointer bit for full/empty.
module cdb_arb_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output cdb_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    cdb_entry_t    mem [DEPTH];

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cdb_result_arbiter.sv
// Queues FU results per unit and broadcasts up to MAX_GRANTS per cycle on the CDB
// with round-robin fairness. Define CDB_ARB_FLUSH_EN to add the flush_i port.
module cdb_result_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned MAX_GRANTS = DEF_MAX_GRANTS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef CDB_ARB_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic [NUM_FU-1:0]             fu_valid_i,
    output logic [NUM_FU-1:0]             fu_ready_o,
    input  logic [NUM_FU-1:0][PREG_W-1:0] fu_preg_i,
    input  logic [NUM_FU-1:0][VAL_W-1:0]  fu_val_i,
    input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag_i,
    input  logic [NUM_FU-1:0][PC_W-1:0]   fu_pc_i,
    input  logic [NUM_FU-1:0]             fu_taken_i,
    input  logic                          cdb_ready_i,
    output logic [NUM_FU-1:0]             cdb_valid_o,
    output logic [NUM_FU-1:0][PREG_W-1:0] cdb_preg_o,
    output logic [NUM_FU-1:0][VAL_W-1:0]  cdb_val_o,
    output logic [NUM_FU-1:0][TAG_W-1:0]  cdb_tag_o,
    output logic [NUM_FU-1:0][PC_W-1:0]   cdb_pc_o,
    output logic [NUM_FU-1:0]             cdb_taken_o
);

    logic              flush;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] win;
    logic [RR_W-1:0]   win_idx [NUM_FU];
    cdb_entry_t        head    [NUM_FU];
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   rr_next;
    logic              advance;
    logic [NUM_FU-1:0] lane_valid;
    cdb_entry_t        lane_data [NUM_FU];

`ifdef CDB_ARB_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign advance     = cdb_ready_i || (lane_valid == '0);
    assign push        = fu_valid_i & ~full & ~{NUM_FU{flush}};
    assign pop         = grant & {NUM_FU{advance && !flush}};
    assign fu_ready_o  = ~full;
    assign cdb_valid_o = lane_valid;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_entry_t din;

        assign din = '{preg: fu_preg_i[i], val: fu_val_i[i], tag: fu_tag_i[i],
                       pc: fu_pc_i[i], taken: fu_taken_i[i]};

        cdb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );

        assign cdb_preg_o[i]  = lane_data[i].preg;
        assign cdb_val_o[i]   = lane_data[i].val;
        assign cdb_tag_o[i]   = lane_data[i].tag;
        assign cdb_pc_o[i]    = lane_data[i].pc;
        assign cdb_taken_o[i] = lane_data[i].taken;
    end

    // Rotate / find-first / unrotate, once per grant, masking earlier winners.
    always_comb begin
        logic [NUM_FU-1:0] avail;
        logic [NUM_FU-1:0] rot;
        logic              found;
        logic [RR_W-1:0]   off;
        logic [RR_W-1:0]   sel;
        avail   = ~empty;
        rot     = '0;
        found   = 1'b0;
        off     = '0;
        sel     = '0;
        grant   = '0;
        win     = '0;
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            win_idx[k] = '0;
        end
        for (int g = 0; g < int'(MAX_GRANTS); g++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                rot[j] = avail[rr_add(rr_ptr, RR_PW'(j))];
            end
            found = 1'b0;
            off   = '0;
            for (int j = NUM_FU - 1; j >= 0; j--) begin
                if (rot[j]) begin
                    found = 1'b1;
                    off   = RR_W'(j);
                end
            end
            sel = rr_add(rr_ptr, {1'b0, off});
            if (found) begin
                win[g]     = 1'b1;
                win_idx[g] = sel;
                avail[sel] = 1'b0;
                grant[sel] = 1'b1;
                rr_next    = rr_add(sel, RR_PW'(1));
            end
        end
    end

    // Output lanes and rr pointer: load on advance, hold while the CDB stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid <= '0;
            rr_ptr     <= '0;
            for (int k = 0; k < NUM_FU; k++) begin
                lane_data[k] <= '0;
            end
        end else if (flush) begin
            lane_valid <= '0;
        end else if (advance) begin
            lane_valid <= win;
            rr_ptr     <= rr_next;
            for (int k = 0; k < NUM_FU; k++) begin
                if (win[k]) begin
                    lane_data[k] <= head[win_idx[k]];
                end else begin
                    lane_data[k] <= '0;
                end
            end
        end
    end

endmodule
